cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Control-phase sequencer for the 8-bit accumulator CPU: drives the datapath strobes (mux select, mem rd/wr,
//  IR/ACC/PC loads) over a fixed 8-phase fetch/execute cycle.
//  Also runs the program-loader mode that streams data_in bytes into instruction memory while Load is high.
//  Sits between the top-level CPU and the PC/IR/ALU/memory datapath.
// PARAMETERS
//  ADDR_W    5   memory address width; loader address counter and PC width
//  OPC_W     3   opcode width (IR[7:5]); encoding fixed below
// PORTS
//  clock    in   1       system clock, rising edge
//  reset    in   1       asynchronous, active-low reset
//  load     in   1       program-load mode request (CPU Load pin)
//  opcode   in   OPC_W   IR[7:5]: HLT=000 SKZ=001 ADD=010 AND=011 XOR=100 LDA=101 STO=110 JMP=111
//  zero     in   1       accumulator == 0
//  sel      out  1       address mux: 1=PC, 0=IR[4:0]
//  rd       out  1       memory read enable
//  wr       out  1       memory write enable (STO)
//  ld_ir    out  1       load IR from memory data
//  ld_ac    out  1       load ACC from ALU result
//  inc_pc   out  1       PC <= PC+1
//  ld_pc    out  1       PC <= IR[4:0]
//  data_e   out  1       drive ACC onto memory data bus
//  pc_clr   out  1       one-cycle pulse: PC <= 0
//  ld_wr    out  1       loader write strobe: mem[ld_addr] <= data_in
//  ld_addr  out  ADDR_W  loader write address
//  halted   out  1       CPU stopped on HLT
//  phase    out  3       current execute phase (debug)
// BEHAVIOUR
//  States: LOAD, START, EXEC (phase 0..7), HALT. Reset: state=START, phase=0, ld_addr=0; all strobes 0.
//  All strobes are decoded from registered state/phase and the opcode (Moore + opcode).
//  START: pc_clr=1 for one cycle, then EXEC phase 0.
//  EXEC: phase increments every cycle; 7 wraps to 0. ALUOP = ADD|AND|XOR|LDA.
//   ph0 INST_ADDR : sel
//   ph1 INST_FETCH: sel rd
//   ph2 INST_LOAD : sel rd ld_ir
//   ph3 IDLE      : sel rd ld_ir
//   ph4 OP_ADDR   : inc_pc; if opcode==HLT, go to HALT next cycle (inc_pc still pulses in ph4)
//   ph5 OP_FETCH  : rd=ALUOP
//   ph6 ALU_OP    : rd=ALUOP; inc_pc=(SKZ&zero); ld_pc=JMP; data_e=STO
//   ph7 STORE     : rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; wr=STO; data_e=STO
//  One instruction = 8 cycles. SKZ with zero=0 is a no-op. JMP holds ld_pc for ph6..ph7.
//  HALT: halted=1, all other strobes 0; held until reset or load=1.
//  LOAD: entered from any state on the edge where load=1 is sampled; it preempts mid-instruction.
//   Pending strobes are dropped and phase is forced to 0.
//   In LOAD: ld_wr=1 every cycle; ld_addr increments after each write; 2**ADDR_W-1 wraps to 0.
//   load 1->0: ld_wr=0, ld_addr resets to 0, next state START. The program restarts at address 0.
//  Priority: reset > load > step gating > normal sequencing.
//  halted=0 in every state except HALT. Async reset mid-instruction clears state with no further strobes.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined:
//   - adds input 'step' (1 bit) and state PAUSE.
//   - after ph7, the sequencer waits in PAUSE with all strobes 0.
//   - a single step=1 cycle resumes at ph0 (one instruction per pulse). step held high = continuous run.
//   - load still preempts PAUSE.
//  SEQ_SINGLE_STEP_EN undefined: no step port and no PAUSE state; ph7 goes straight to ph0.
// TESTING
//  1 Reset low 2 cycles, release -> pc_clr=1 one cycle, then phase 0..7 repeating; halted=0.
//  2 load=1 for 22 cycles -> ld_wr=1 with ld_addr 0..21; drop load -> ld_addr=0, then pc_clr pulse.
//  3 opcode=010 (ADD) -> ph2/ph3 ld_ir; ph4 inc_pc; ph5-7 rd; ld_ac only in ph7; wr never asserted.
//  4 opcode=110 (STO) -> ph6 data_e; ph7 data_e+wr; rd/ld_ac=0. opcode=111 (JMP) -> ld_pc in ph6,ph7.
//  5 SKZ: zero=1 -> inc_pc in ph4 and ph6; zero=0 -> inc_pc only in ph4.
//    HLT -> halted=1 from cycle after ph4; strobes stay 0 for 20 cycles.
//  6 Mid-ph5 load=1 -> next cycle LOAD, ld_addr=0, no ld_ac; 40-cycle load -> ld_addr wraps 31->0.
//    Step mode: PAUSE after ph7 until one step pulse.

Source files
------------

// File: rtl/cpu_sequencer.sv
// ============================================================================
// Module  : cpu_sequencer
// Purpose : 8-phase fetch/execute strobe sequencer with program-loader mode.
//           Optional single-step support when SEQ_SINGLE_STEP_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_sequencer #(
  parameter int ADDR_W = 5,
  parameter int OPC_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              zero,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              sel,
  output logic              rd,
  output logic              wr,
  output logic              ld_ir,
  output logic              ld_ac,
  output logic              inc_pc,
  output logic              ld_pc,
  output logic              data_e,
  output logic              pc_clr,
  output logic              ld_wr,
  output logic [ADDR_W-1:0] ld_addr,
  output logic              halted,
  output logic [2:0]        phase
);

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_START = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_PAUSE = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [2:0]        phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic alu_op, is_sto, is_jmp, is_skz;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_START;
      phase_q <= 3'd0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    sel     = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    ld_ir   = 1'b0;
    ld_ac   = 1'b0;
    inc_pc  = 1'b0;
    ld_pc   = 1'b0;
    data_e  = 1'b0;
    pc_clr  = 1'b0;
    ld_wr   = 1'b0;
    halted  = 1'b0;

    alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
             (opcode == OP_XOR) || (opcode == OP_LDA);
    is_sto = (opcode == OP_STO);
    is_jmp = (opcode == OP_JMP);
    is_skz = (opcode == OP_SKZ);

    // Load preempts everything, including a half-finished instruction.
    if (load) begin
      state_d = S_LOAD;
      phase_d = 3'd0;
      addr_d  = (state_q == S_LOAD) ? addr_q + ADDR_W'(1) : '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          state_d = S_START;
          addr_d  = '0;
        end
        S_START: begin
          state_d = S_EXEC;
          phase_d = 3'd0;
        end
        S_EXEC: begin
          if (phase_q == 3'd4 && opcode == OP_HLT) begin
            state_d = S_HALT;
            phase_d = 3'd0;
          end else if (phase_q == 3'd7) begin
`ifdef SEQ_SINGLE_STEP_EN
            state_d = S_PAUSE;
`endif
            phase_d = 3'd0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step) begin
            state_d = S_EXEC;
            phase_d = 3'd0;
          end
        end
`endif
        default: ;
      endcase
    end

    // Strobes are held low while reset is asserted, even though the state reads START.
    if (reset) begin
      case (state_q)
        S_LOAD:  ld_wr  = 1'b1;
        S_START: pc_clr = 1'b1;
        S_HALT:  halted = 1'b1;
        S_EXEC: begin
          case (phase_q)
            3'd0: sel = 1'b1;
            3'd1: begin
              sel = 1'b1;
              rd  = 1'b1;
            end
            3'd2, 3'd3: begin
              sel   = 1'b1;
              rd    = 1'b1;
              ld_ir = 1'b1;
            end
            3'd4: inc_pc = 1'b1;
            3'd5: rd = alu_op;
            3'd6: begin
              rd     = alu_op;
              inc_pc = is_skz & zero;
              ld_pc  = is_jmp;
              data_e = is_sto;
            end
            default: begin
              rd     = alu_op;
              ld_ac  = alu_op;
              ld_pc  = is_jmp;
              wr     = is_sto;
              data_e = is_sto;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign ld_addr = addr_q;
  assign phase   = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// Module  : tb_cpu_sequencer
// Purpose : Directed scoreboard bench for cpu_sequencer (default build).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load  = 1'b0;
  logic       zero  = 1'b0;
  logic [2:0] opcode = 3'b010;

  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, pc_clr, ld_wr, halted;
  logic [4:0] ld_addr;
  logic [2:0] phase;

  cpu_sequencer #(.ADDR_W(5), .OPC_W(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .pc_clr (pc_clr),
    .ld_wr  (ld_wr),
    .ld_addr(ld_addr),
    .halted (halted),
    .phase  (phase)
  );

  always #5 clock = ~clock;

  // Strobe bit positions inside the 11-bit strobe word.
  localparam logic [10:0] B_SEL = 11'h400;
  localparam logic [10:0] B_RD  = 11'h200;
  localparam logic [10:0] B_WR  = 11'h100;
  localparam logic [10:0] B_IR  = 11'h080;
  localparam logic [10:0] B_AC  = 11'h040;
  localparam logic [10:0] B_INC = 11'h020;
  localparam logic [10:0] B_LPC = 11'h010;
  localparam logic [10:0] B_DE  = 11'h008;
  localparam logic [10:0] B_CLR = 11'h004;
  localparam logic [10:0] B_LWR = 11'h002;
  localparam logic [10:0] B_HLT = 11'h001;

  localparam logic [18:0] M_FULL = 19'h7FFFF;
  localparam logic [18:0] M_NOPH = 19'h7FF1F;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, XOR = 3'b100;
  localparam logic [2:0] STO = 3'b110, JMP = 3'b111;

  typedef struct {
    logic [18:0] exp;
    logic [18:0] mask;
    string       tag;
  } item_t;

  item_t sb[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [10:0] exp_exec(input int ph, input logic [2:0] op, input logic z);
    logic alu, sto, jmp, skz;
    logic [10:0] r;
    alu = (op == 3'b010) || (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    sto = (op == 3'b110);
    jmp = (op == 3'b111);
    skz = (op == 3'b001);
    r = 11'h0;
    case (ph)
      0:       r = B_SEL;
      1:       r = B_SEL | B_RD;
      2, 3:    r = B_SEL | B_RD | B_IR;
      4:       r = B_INC;
      5:       r = alu ? B_RD : 11'h0;
      6:       r = (alu ? B_RD : 11'h0) | ((skz && z) ? B_INC : 11'h0) |
                   (jmp ? B_LPC : 11'h0) | (sto ? B_DE : 11'h0);
      default: r = (alu ? (B_RD | B_AC) : 11'h0) | (jmp ? B_LPC : 11'h0) |
                   (sto ? (B_WR | B_DE) : 11'h0);
    endcase
    return r;
  endfunction

  task automatic push(input string tag, input logic [10:0] strb, input int ph,
                      input int addr, input logic [18:0] mask);
    item_t it;
    it.exp  = {strb, 3'(ph), 5'(addr)};
    it.mask = mask;
    it.tag  = tag;
    sb.push_back(it);
  endtask

  task automatic check_now();
    item_t       it;
    logic [18:0] obs;
    obs = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, pc_clr, ld_wr, halted, phase, ld_addr};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      it = sb.pop_front();
      assert ((obs & it.mask) === (it.exp & it.mask))
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs & it.mask, it.exp & it.mask);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check_now();
  endtask

  task automatic run_exec(input string tag, input logic [2:0] op, input logic z,
                          input int first_ph, input int last_ph);
    for (int ph = first_ph; ph <= last_ph; ph++) begin
      opcode = op;
      zero   = z;
      push($sformatf("%s_ph%0d", tag, ph), exp_exec(ph, op, z), ph, 0, M_FULL);
      tick();
    end
  endtask

  initial begin
    // Reset held for two cycles: everything quiet.
    repeat (2) begin
      push("reset", 11'h0, 0, 0, M_FULL);
      tick();
    end
    reset = 1'b1;
    push("start_pc_clr", B_CLR, 0, 0, M_FULL);
    #1;
    check_now();

    run_exec("add", ADD, 1'b0, 0, 7);
    run_exec("sto", STO, 1'b0, 0, 7);
    run_exec("jmp", JMP, 1'b0, 0, 7);
    run_exec("skz_z1", SKZ, 1'b1, 0, 7);
    run_exec("skz_z0", SKZ, 1'b0, 0, 7);

    // Load requested in ph5 of an ADD: no ld_ac, straight into loading from address 0.
    run_exec("add_pre_load", ADD, 1'b0, 0, 5);
    load = 1'b1;
    for (int k = 0; k < 22; k++) begin
      push($sformatf("load22_%0d", k), B_LWR, 0, k, M_FULL);
      tick();
    end
    load = 1'b0;
    push("load_exit", B_CLR, 0, 0, M_FULL);
    tick();

    run_exec("hlt", HLT, 1'b0, 0, 4);
    for (int k = 0; k < 20; k++) begin
      push($sformatf("halt_%0d", k), B_HLT, 0, 0, M_NOPH);
      tick();
    end

    // Load out of HALT, long enough to wrap the 5-bit address.
    load = 1'b1;
    for (int k = 0; k < 40; k++) begin
      push($sformatf("load40_%0d", k), B_LWR, 0, k % 32, M_FULL);
      tick();
    end
    load = 1'b0;
    push("load40_exit", B_CLR, 0, 0, M_FULL);
    tick();

    // Asynchronous reset mid-instruction.
    run_exec("add_pre_rst", ADD, 1'b1, 0, 3);
    reset = 1'b0;
    push("async_rst", 11'h0, 0, 0, M_FULL);
    #1;
    check_now();
    push("async_rst_hold", 11'h0, 0, 0, M_FULL);
    tick();
    reset = 1'b1;
    push("restart_pc_clr", B_CLR, 0, 0, M_FULL);
    #1;
    check_now();
    run_exec("xor", XOR, 1'b0, 0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
